// File: rtl/shift_unit_if.sv
// Bus bundle for shift_unit: request operands from the master, status and result from the unit.
// start is a request that is taken only while busy=0; done is a one-cycle result strobe with y valid.
interface shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, a, shamt,
    input  busy, done, y, dbg_state
  );

  modport slave (
    input  start, op, a, shamt,
    output busy, done, y, dbg_state
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: one bit per SHIFT cycle for SLL/SRL/SRA/ROR, result registered on entry to DONE.
// Handshake: start is accepted only in IDLE (busy=0); done pulses for one cycle with y valid; y then holds.
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [WIDTH-1:0] y_q, y_next;
  logic [SHW-1:0]   cnt, cnt_next;
  logic [1:0]       op_q, op_next;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] step1(input logic [1:0] o, input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      default: r = {w[0], w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  assign step_val = step1(op_q, work);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      y_q   <= '0;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_next;
      work  <= work_next;
      y_q   <= y_next;
      cnt   <= cnt_next;
      op_q  <= op_next;
    end
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    y_next     = y_q;
    cnt_next   = cnt;
    op_next    = op_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          work_next = bus.a;
          op_next   = bus.op;
          cnt_next  = bus.shamt;
          if (bus.shamt == '0) begin
            state_next = DONE;
            y_next     = bus.a;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next = step_val;
        cnt_next  = cnt - SHW'(1);
        // cnt can never be 0 here; treating it like 1 keeps the FSM from wrapping through 2^SHW steps.
        if (cnt <= SHW'(1)) begin
          state_next = DONE;
          y_next     = step_val;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.y         = y_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: expected results queued at request time and checked on each done pulse.
module tb_shift_unit;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) sif ();

  shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_y;
  int done_cycs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input int sh);
    logic [2*WIDTH-1:0] aa;
    logic [WIDTH-1:0]   r;
    aa = {a, a};
    case (op)
      2'd0:    r = WIDTH'(a << sh);
      2'd1:    r = WIDTH'(a >> sh);
      2'd2:    r = WIDTH'($signed(a) >>> sh);
      default: r = WIDTH'(aa >> sh);
    endcase
    return r;
  endfunction

  // One clock; outputs sampled on the falling edge. Every done pulse is scored, y must hold otherwise.
  task automatic tick();
    logic r;
    logic [WIDTH-1:0] e;
    r = reset;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (sif.busy) busy_cnt++;
    if (sif.done) begin
      done_cnt++;
      done_cycs.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(sif.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("y_on_done", 32'(sif.y), 32'(e));
      end
    end else if (!r) begin
      check("y_hold", 32'(sif.y), 32'(last_y));
    end
    last_y = sif.y;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                     input logic [SHW-1:0] sh, input logic [WIDTH-1:0] exp);
    int n;
    int d0;
    sif.start = 1'b1;
    sif.op    = op;
    sif.a     = a;
    sif.shamt = sh;
    exp_q.push_back(exp);
    busy_cnt = 0;
    d0 = done_cnt;
    tick();
    sif.start = 1'b0;
    n = 1;
    while (!sif.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(sh) + 32'd1);
    check({tag, "_busy_in_done"}, 32'(sif.busy), 32'd1);
    tick();
    check({tag, "_busy_after"}, 32'(sif.busy), 32'd0);
    check({tag, "_done_after"}, 32'(sif.done), 32'd0);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(sh) + 32'd1);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int n;
    int d0;
    int c0;
    logic [1:0]       rop;
    logic [WIDTH-1:0] ra;
    logic [SHW-1:0]   rsh;

    reset     = 1'b1;
    sif.start = 1'b0;
    sif.op    = 2'd0;
    sif.a     = '0;
    sif.shamt = '0;
    tick();
    tick();
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_y", 32'(sif.y), 32'd0);
    check("rst_state", 32'(sif.dbg_state), 32'd0);

    // First request lands in the very first cycle out of reset.
    reset = 1'b0;
    run("sll_1_4", 2'd0, 16'h0001, 4'd4, 16'h0010);
    run("sra_8000_15", 2'd2, 16'h8000, 4'd15, 16'hFFFF);
    run("srl_8000_15", 2'd1, 16'h8000, 4'd15, 16'h0001);
    run("ror_1234_4", 2'd3, 16'h1234, 4'd4, 16'h4123);
    run("sll_beef_0", 2'd0, 16'hBEEF, 4'd0, 16'hBEEF);
    run("srl_beef_0", 2'd1, 16'hBEEF, 4'd0, 16'hBEEF);
    run("sra_beef_0", 2'd2, 16'hBEEF, 4'd0, 16'hBEEF);
    run("ror_beef_0", 2'd3, 16'hBEEF, 4'd0, 16'hBEEF);
    run("sra_7ff0_15", 2'd2, 16'h7FF0, 4'd15, 16'h0000);
    run("ror_0001_15", 2'd3, 16'h0001, 4'd15, 16'h0002);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = WIDTH'($urandom_range(0, 65535));
      rsh = SHW'($urandom_range(0, WIDTH - 1));
      run("rand", rop, ra, rsh, model(rop, ra, int'(rsh)));
    end

    // Operands and start changing while busy must not disturb the in-flight SRL.
    sif.start = 1'b1;
    sif.op    = 2'd1;
    sif.a     = 16'hF000;
    sif.shamt = 4'd8;
    exp_q.push_back(16'h00F0);
    d0 = done_cnt;
    tick();
    sif.op    = 2'd0;
    sif.a     = 16'h1234;
    sif.shamt = 4'd3;
    tick();
    tick();
    sif.start = 1'b0;
    n = 3;
    while (!sif.done && n < 40) begin
      tick();
      n++;
    end
    check("midchg_latency", 32'(n), 32'd9);
    repeat (4) tick();
    check("midchg_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset during the 4th SHIFT cycle aborts with no done pulse.
    sif.start = 1'b1;
    sif.op    = 2'd0;
    sif.a     = 16'h0003;
    sif.shamt = 4'd10;
    d0 = done_cnt;
    tick();
    sif.start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_in_shift", 32'(sif.dbg_state), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_busy", 32'(sif.busy), 32'd0);
    check("abort_y", 32'(sif.y), 32'd0);
    check("abort_done", 32'(sif.done), 32'd0);
    check("abort_state", 32'(sif.dbg_state), 32'd0);
    reset = 1'b0;
    repeat (20) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // start held high: acceptances every shamt+2 cycles pick up the operand present in that IDLE cycle.
    sif.start = 1'b1;
    sif.op    = 2'd3;
    sif.shamt = 4'd2;
    done_cycs.delete();
    d0 = done_cnt;
    c0 = cyc;
    for (int k = 0; k < 16; k += 4) exp_q.push_back(model(2'd3, 16'h0100 + 16'(k), 2));
    for (int k = 0; k < 16; k++) begin
      sif.a = 16'h0100 + 16'(k);
      tick();
    end
    sif.start = 1'b0;
    tick();
    tick();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd4);
    if (done_cycs.size() == 4) begin
      for (int i = 0; i < 4; i++) check("b2b_done_cycle", 32'(done_cycs[i] - c0), 32'(3 + 4 * i));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits.
REQ-002 Parameter SHW, default 4, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-007 a  input  WIDTH  operand.
REQ-008 shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; y valid in that cycle.
REQ-011 y  output  WIDTH  registered result.

Function
REQ-012 The unit SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL latch a into the work register, op into the op register and shamt into the down-counter cnt.
REQ-014 From IDLE, start=1 with shamt!=0 SHALL go to SHIFT; start=1 with shamt=0 SHALL go to DONE; start=0 SHALL stay in IDLE.
REQ-015 Each SHIFT cycle SHALL shift the work register by exactly one bit and decrement cnt by 1.
REQ-016 The one-bit step SHALL be:
- SLL: {w[WIDTH-2:0],0}
- SRL: {0,w[WIDTH-1:1]}
- SRA: {w[WIDTH-1],w[WIDTH-1:1]}
- ROR: {w[0],w[WIDTH-1:1]}
REQ-017 SHIFT with cnt=1 SHALL apply the final step and go to DONE; otherwise it SHALL stay in SHIFT.
REQ-018 On the transition into DONE, y SHALL load the final work value (for shamt=0, y=a).
REQ-019 In DONE, done SHALL be 1 for exactly one cycle and the next state SHALL be IDLE unconditionally.
REQ-020 Latency: with start sampled at edge 0, done SHALL be high in cycle max(shamt,0)+1, i.e. shamt+1 cycles after acceptance (shamt=0 gives 1).
REQ-021 y SHALL hold its value from DONE until the next entry into DONE; it SHALL not show intermediate values.
REQ-022 start, op, a and shamt SHALL be ignored while busy=1; in-flight operands SHALL not change.
REQ-023 start=1 in the DONE cycle SHALL be ignored; a new request SHALL be accepted no earlier than the following IDLE cycle, giving back-to-back throughput of one op per shamt+2 cycles.
REQ-024 done and busy SHALL be decoded from state registers only, with no combinational path from inputs.
REQ-025 All arithmetic SHALL be unsigned except for SRA sign replication; results SHALL be truncated to WIDTH bits.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=IDLE, y=0, work=0, cnt=0, done=0 and busy=0, overriding any other input.
REQ-027 reset asserted during SHIFT or DONE SHALL abort the operation: no done pulse, y=0, and IDLE on the next cycle.
REQ-028 The first start SHALL be accepted in the first cycle with reset=0.

Verification
REQ-029 SLL: a=0x0001, shamt=4, op=00 -> busy for 5 cycles; done in cycle 5; y=0x0010.
REQ-030 SRA: a=0x8000, shamt=15, op=10 -> done in cycle 16; y=0xFFFF. SRL with the same inputs (op=01) -> y=0x0001.
REQ-031 ROR: a=0x1234, shamt=4, op=11 -> y=0x4123. shamt=0 with any op, a=0xBEEF -> done in cycle 1; y=0xBEEF.
REQ-032 Mid-operation input change: start SRL with a=0xF000, shamt=8, then change a/op/shamt and pulse start during busy -> y=0x00F0; exactly one done pulse.
REQ-033 Reset abort: start with shamt=10, assert reset in the 4th SHIFT cycle -> next cycle busy=0, y=0, and no done pulse at any later cycle.
REQ-034 Back-to-back: hold start=1 continuously with shamt=2 -> done pulses repeat every 4 cycles, with y updated only in the done cycles.
